osc_tick_gen: RTL and testbench
===============================

# osc_tick_gen

Parametrised multi-channel clock-enable generator driven from the on-chip RC oscillator fabric clock (1 MHz RCOSC_1MHZ_O2F, or any other oscillator fabric output). Produces NUM_CH independent single-cycle tick strobes with runtime-programmable divide ratios and periodic/one-shot modes. Downstream fabric logic uses these strobes as slow timebases (watchdog, LED, housekeeping) instead of deriving extra clock nets.

## Interface
- NUM_CH, 4, number of tick channels (1..16)
- DIV_W, 16, width of divide value and per-channel counter
- DEFAULT_DIV, 1000, divide value loaded into every channel at reset (1 MHz -> 1 kHz)
- CH_W, derived, max(1, clog2(NUM_CH)), width of channel select

- CLK  in  1  oscillator fabric clock; all logic on rising edge
- RESETN  in  1  synchronous, active-low reset
- CFG_WE  in  1  config write request
- CFG_CH  in  CH_W  target channel of write
- CFG_DIV  in  DIV_W  divide value (tick every CFG_DIV cycles; 0 treated as 1)
- CFG_MODE  in  1  0 = periodic, 1 = one-shot
- CFG_READY  out  1  write accepted when CFG_WE && CFG_READY
- CFG_ERR  out  1  one-cycle pulse: accepted write had CFG_CH >= NUM_CH
- CH_EN  in  NUM_CH  per-channel run enable
- SYNC_RESTART  in  1  restart all channels phase-aligned
- TICK  out  NUM_CH  one-cycle strobe per channel
- DONE  out  NUM_CH  sticky: one-shot channel has fired

## Operation
- Per channel: DIV register, MODE register, pending DIV/MODE + pending flag, down counter CNT[DIV_W-1:0], DONE flag.
- Effective divide D = max(DIV,1). Counter reload value D-1.
- Channel states: IDLE (CH_EN=0), RUN, FIRED (one-shot after tick).
- IDLE: CNT held at D-1, TICK=0. Pending config applied immediately. DONE cleared.
- IDLE->RUN when CH_EN sampled 1. RUN: CNT decrements each cycle; when CNT==0, TICK=1 for that cycle and CNT reloads D-1 (pending config applied at this reload, pending cleared).
- One-shot: on first tick RUN->FIRED; DONE set; CNT frozen; TICK=0 thereafter. FIRED->IDLE only on CH_EN=0; SYNC_RESTART returns FIRED->RUN.
- Any state ->IDLE when CH_EN=0 (abort mid-count, no tick).
- Config write: accepted on CFG_WE && CFG_READY. Valid CFG_CH: loads pending DIV/MODE for that channel (overwrites earlier pending value). Invalid CFG_CH: no state change, CFG_ERR pulses next cycle.
- CFG_READY drops for exactly one cycle after each accepted write (max one write per 2 cycles); CFG_WE while CFG_READY=0 is ignored.
- SYNC_RESTART: all channels apply pending config, CNT = D-1, DONE cleared, FIRED->RUN (if CH_EN=1); no TICK in that cycle. Priority: RESETN > CH_EN=0 > SYNC_RESTART > terminal-count tick.
- Write and terminal count same cycle on same channel: tick uses old D, new value goes pending, applied at this reload only if write accepted in an earlier cycle (i.e., pending registered before the reload edge).

## Timing
- Reset values: TICK=0, DONE=0, CFG_ERR=0, CFG_READY=1, every DIV=DEFAULT_DIV, MODE=0, pending=0, CNT=DEFAULT_DIV-1.
- First TICK: D cycles after the first edge at which CH_EN samples 1 (cycle index D-1 counting that edge as cycle 0). Subsequent ticks exactly D cycles apart.
- D=1: TICK high every cycle while RUN.
- CFG_ERR: registered, 1 cycle after acceptance edge. CFG_READY low in cycle after acceptance.
- Config applied no earlier than the edge after acceptance; never changes a period in progress while RUN.
- TICK, DONE, CFG_READY, CFG_ERR all registered outputs; no combinational path from inputs.
- Reset mid-count: all outputs at reset values on the edge RESETN sampled 0; pending writes discarded.

## Test plan
- Reset, CH_EN=0001, DEFAULT_DIV=1000 -> TICK[0] first at cycle 999 after enable, then every 1000 cycles; other TICK bits stay 0.
- Write CH1 DIV=5 MODE=1, then CH_EN[1]=1 -> single TICK[1] at cycle 4, DONE[1]=1 held; SYNC_RESTART -> DONE[1]=0, another tick 5 cycles later.
- CH0 running DIV=10, write DIV=3 mid-period -> current period completes at 10 cycles, subsequent ticks every 3 cycles.
- NUM_CH=3, write CFG_CH=3 -> CFG_ERR pulse 1 cycle, no channel changes; back-to-back CFG_WE -> second write dropped (CFG_READY=0).
- DIV=0 and DIV=1 -> TICK high every RUN cycle; CH_EN drop at CNT=2 of DIV=8 -> no tick, re-enable restarts full 8-cycle period.
- RESETN=0 mid-count with pending write -> all outputs reset next edge, DIV back to 1000, pending lost.

Source files
------------

// File: rtl/osc_tick_gen.sv
// Multi-channel tick-strobe generator: per-channel down counters with runtime divide ratio and periodic/one-shot modes.
// All outputs are registered. CFG_READY drops for one cycle after each accepted write, so writes are accepted at most every other cycle.
module osc_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              CFG_MODE,
  output logic              CFG_READY,
  output logic              CFG_ERR,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              SYNC_RESTART,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIRED} state_e;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_CNT = (DEFAULT_DIV > 1) ? DIV_W'(DEFAULT_DIV - 1) : '0;
  localparam logic [CH_W:0]    CH_LIM  = (CH_W+1)'(NUM_CH);

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] pdiv_q  [NUM_CH];
  logic [DIV_W-1:0] pdiv_d  [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d, pmode_q, pmode_d, pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d, done_q, done_d, apply_s;
  logic              cfg_rdy_q, cfg_rdy_d, cfg_err_q, cfg_err_d;
  logic              wr_ok, wr_hit;

  // A divide value of 0 behaves as 1, so the reload value is max(div,1)-1.
  function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  assign wr_ok  = CFG_WE && cfg_rdy_q;
  assign wr_hit = wr_ok && ({1'b0, CFG_CH} < CH_LIM);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cfg_rdy_q <= 1'b1;
      cfg_err_q <= 1'b0;
      tick_q    <= '0;
      done_q    <= '0;
      mode_q    <= '0;
      pmode_q   <= '0;
      pend_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= RST_CNT;
        div_q[i]   <= DEF_DIV;
        pdiv_q[i]  <= '0;
      end
    end else begin
      cfg_rdy_q <= cfg_rdy_d;
      cfg_err_q <= cfg_err_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      pmode_q   <= pmode_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pdiv_q    <= pdiv_d;
    end
  end

  // Priority: disable > sync restart > terminal count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      if (!CH_EN[i]) begin
        state_d[i] = S_IDLE;
      end else if (SYNC_RESTART) begin
        state_d[i] = S_RUN;
      end else if (state_q[i] != S_FIRED) begin
        state_d[i] = (cnt_q[i] == '0 && mode_q[i]) ? S_FIRED : S_RUN;
      end
    end
  end

  always_comb begin
    cfg_rdy_d = !wr_ok;
    cfg_err_d = wr_ok && !wr_hit;
    tick_d    = '0;
    done_d    = done_q;
    mode_d    = mode_q;
    pmode_d   = pmode_q;
    pend_d    = pend_q;
    apply_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
      if (!CH_EN[i] || SYNC_RESTART) begin
        apply_s[i] = 1'b1;
        done_d[i]  = 1'b0;
      end else if (state_q[i] != S_FIRED) begin
        if (cnt_q[i] == '0) begin
          tick_d[i]  = 1'b1;
          apply_s[i] = 1'b1;
          if (mode_q[i]) done_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - DIV_W'(1);
        end
      end
      // Pending config only lands at a reload, so a running period is never stretched or cut.
      if (apply_s[i]) begin
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          mode_d[i] = pmode_q[i];
          pend_d[i] = 1'b0;
        end
        cnt_d[i] = reload_of(pend_q[i] ? pdiv_q[i] : div_q[i]);
      end
      if (wr_hit && CFG_CH == CH_W'(i)) begin
        pend_d[i]  = 1'b1;
        pdiv_d[i]  = CFG_DIV;
        pmode_d[i] = CFG_MODE;
      end
    end
  end

  assign TICK      = tick_q;
  assign DONE      = done_q;
  assign CFG_READY = cfg_rdy_q;
  assign CFG_ERR   = cfg_err_q;

endmodule

// File: tb/tb_osc_tick_gen.sv
// Scoreboard bench: a time-based reference model predicts every cycle's outputs; a negedge monitor checks them.
module tb_osc_tick_gen;
  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int DEF = 1000;
  localparam int CHW = 2;

  logic           CLK = 1'b0;
  logic           RESETN = 1'b0;
  logic           CFG_WE = 1'b0;
  logic [CHW-1:0] CFG_CH = '0;
  logic [DW-1:0]  CFG_DIV = '0;
  logic           CFG_MODE = 1'b0;
  logic           CFG_READY, CFG_ERR;
  logic [NCH-1:0] CH_EN = '0;
  logic           SYNC_RESTART = 1'b0;
  logic [NCH-1:0] TICK, DONE;

  osc_tick_gen #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
    .CLK(CLK), .RESETN(RESETN), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV),
    .CFG_MODE(CFG_MODE), .CFG_READY(CFG_READY), .CFG_ERR(CFG_ERR), .CH_EN(CH_EN),
    .SYNC_RESTART(SYNC_RESTART), .TICK(TICK), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] done;
    logic           rdy;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_g;
  int   n_chk = 0;
  int   n_fail = 0;
  int   dut_ticks[NCH];
  int   mdl_ticks[NCH];

  // Reference model: ticks are scheduled as absolute edge numbers rather than counted down.
  longint      cyc = 0;
  longint      m_next[NCH];
  int unsigned m_d[NCH], m_pd[NCH];
  bit          m_mode[NCH], m_pmode[NCH], m_pend[NCH], m_act[NCH], m_fired[NCH], m_done[NCH];
  bit          m_rdy = 1'b1;
  bit          m_err = 1'b0;

  function automatic longint eff(input int unsigned d);
    return (d == 0) ? 64'd1 : longint'(d);
  endfunction

  task automatic apply_pend(input int ch);
    if (m_pend[ch]) begin
      m_d[ch]    = m_pd[ch];
      m_mode[ch] = m_pmode[ch];
      m_pend[ch] = 1'b0;
    end
  endtask

  task automatic model_edge();
    exp_t e;
    bit   acc;
    e = '0;
    if (!RESETN) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_d[ch] = DEF; m_mode[ch] = 0; m_pend[ch] = 0;
        m_act[ch] = 0; m_fired[ch] = 0; m_done[ch] = 0;
      end
      m_rdy = 1'b1;
      m_err = 1'b0;
    end else begin
      acc = CFG_WE && m_rdy;
      for (int ch = 0; ch < NCH; ch++) begin
        if (!CH_EN[ch]) begin
          m_act[ch] = 0; m_fired[ch] = 0; m_done[ch] = 0;
          apply_pend(ch);
        end else if (SYNC_RESTART) begin
          apply_pend(ch);
          m_act[ch] = 1; m_fired[ch] = 0; m_done[ch] = 0;
          m_next[ch] = cyc + eff(m_d[ch]);
        end else begin
          // The enabling edge is itself the first counted cycle.
          if (!m_act[ch]) begin
            m_act[ch] = 1;
            m_next[ch] = cyc + eff(m_d[ch]) - 1;
          end
          if (!m_fired[ch] && cyc == m_next[ch]) begin
            e.tick[ch] = 1'b1;
            mdl_ticks[ch]++;
            if (m_mode[ch]) begin
              m_fired[ch] = 1; m_done[ch] = 1;
            end
            apply_pend(ch);
            m_next[ch] = cyc + eff(m_d[ch]);
          end
        end
      end
      m_err = acc && (int'(CFG_CH) >= NCH);
      if (acc && int'(CFG_CH) < NCH) begin
        m_pend[CFG_CH] = 1'b1;
        m_pd[CFG_CH] = CFG_DIV;
        m_pmode[CFG_CH] = CFG_MODE;
      end
      m_rdy = !acc;
    end
    for (int ch = 0; ch < NCH; ch++) e.done[ch] = m_done[ch];
    e.rdy = m_rdy;
    e.err = m_err;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int div, input bit mode);
    CFG_WE = 1'b1; CFG_CH = CHW'(ch); CFG_DIV = DW'(div); CFG_MODE = mode;
    step();
    CFG_WE = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g = {TICK, DONE, CFG_READY, CFG_ERR};
      for (int ch = 0; ch < NCH; ch++) if (TICK[ch]) dut_ticks[ch]++;
      n_chk++;
      if (mon_g !== mon_e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got tick=%b done=%b rdy=%b err=%b, expected tick=%b done=%b rdy=%b err=%b",
                 $time, mon_g.tick, mon_g.done, mon_g.rdy, mon_g.err,
                 mon_e.tick, mon_e.done, mon_e.rdy, mon_e.err);
      end
    end
  end

  initial begin
    steps(3);
    RESETN = 1'b1;
    // Default divide on channel 0 only.
    CH_EN = 3'b001;
    steps(2100);
    CH_EN = '0;
    steps(2);
    // One-shot channel 1, then a sync restart re-arms it.
    wr(1, 5, 1'b1);
    steps(2);
    CH_EN = 3'b010;
    steps(10);
    SYNC_RESTART = 1'b1;
    step();
    SYNC_RESTART = 1'b0;
    steps(8);
    CH_EN = '0;
    step();
    // Mid-period divide change on channel 0.
    wr(0, 10, 1'b0);
    steps(2);
    CH_EN = 3'b001;
    steps(4);
    wr(0, 3, 1'b0);
    steps(20);
    CH_EN = '0;
    step();
    // Out-of-range channel, then back-to-back writes.
    wr(3, 7, 1'b0);
    step();
    CFG_WE = 1'b1; CFG_CH = 2'd2; CFG_DIV = 16'd4;
    step();
    CFG_DIV = 16'd9;
    step();
    CFG_WE = 1'b0;
    steps(3);
    // Divide 0 and 1, then abort at count 2 of divide 8.
    wr(2, 0, 1'b0);
    steps(2);
    CH_EN = 3'b100;
    steps(5);
    wr(2, 1, 1'b0);
    steps(5);
    CH_EN = '0;
    wr(0, 8, 1'b0);
    steps(2);
    CH_EN = 3'b001;
    steps(5);
    CH_EN = '0;
    step();
    CH_EN = 3'b001;
    steps(20);
    // Reset mid-count with a pending write.
    CH_EN = 3'b011;
    wr(1, 6, 1'b0);
    RESETN = 1'b0;
    step();
    RESETN = 1'b1;
    steps(1005);
    // Randomized traffic with small divides.
    for (int k = 0; k < 4000; k++) begin
      RESETN       = ($urandom_range(0, 599) != 0);
      CFG_WE       = ($urandom_range(0, 5) == 0);
      CFG_CH       = CHW'($urandom_range(0, 3));
      CFG_DIV      = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(10, 40)) : DW'($urandom_range(0, 9));
      CFG_MODE     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) CH_EN = NCH'($urandom_range(0, 7));
      SYNC_RESTART = ($urandom_range(0, 39) == 0);
      step();
    end
    CFG_WE = 1'b0;
    SYNC_RESTART = 1'b0;
    steps(2);
    @(negedge CLK);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    for (int ch = 0; ch < NCH; ch++) begin
      n_chk++;
      if (dut_ticks[ch] != mdl_ticks[ch]) begin
        n_fail++;
        $display("FAIL tick_count ch%0d: got %0d, required %0d", ch, dut_ticks[ch], mdl_ticks[ch]);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
